// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 1-cycle hit path, whole-line refill
// from the memory controller, one word per beat.
module instruction_cache #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        pcValid,
    input  logic [31:0] pcIn,
    output logic        instrOutValid,
    output logic [31:0] instrOut,
    output logic [31:0] instrAddrOut,
    output logic        memReqValid,
    output logic [31:0] memReqAddr,
    input  logic        memReqReady,
    input  logic        memDataValid,
    input  logic [31:0] memData
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
    localparam int TAG_BITS = 32 - TAG_LSB;

    typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;

    state_t                  state, stateNext;
    logic [LINES-1:0]        validArr;
    logic [TAG_BITS-1:0]     tagArr  [LINES];
    logic [31:0]             dataArr [LINES][WORDS];
    logic [31:0]             missAddr;
    logic [OFFSET_BITS-1:0]  beatCnt;

    logic [INDEX_BITS-1:0]   pcIndex, missIndex;
    logic [OFFSET_BITS-1:0]  pcOffset;
    logic [TAG_BITS-1:0]     pcTag, missTag;
    logic                    hit, lastBeat;

    assign pcOffset  = pcIn[OFFSET_BITS+1:2];
    assign pcIndex   = pcIn[TAG_LSB-1:OFFSET_BITS+2];
    assign pcTag     = pcIn[31:TAG_LSB];
    assign missIndex = missAddr[TAG_LSB-1:OFFSET_BITS+2];
    assign missTag   = missAddr[31:TAG_LSB];

    assign hit      = validArr[pcIndex] && (tagArr[pcIndex] == pcTag);
    assign lastBeat = memDataValid && (beatCnt == {OFFSET_BITS{1'b1}});

    assign memReqValid = (state == REQ);
    assign memReqAddr  = missAddr;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (pcValid && !hit) stateNext = REQ;
            REQ:     if (memReqReady)     stateNext = REFILL;
            REFILL:  if (lastBeat)        stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state         <= IDLE;
            validArr      <= '0;
            beatCnt       <= '0;
            missAddr      <= '0;
            instrOutValid <= 1'b0;
            instrOut      <= '0;
            instrAddrOut  <= '0;
        end else begin
            state         <= stateNext;
            instrOutValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pcValid && hit) begin
                        instrOutValid <= 1'b1;
                        instrOut      <= dataArr[pcIndex][pcOffset];
                        instrAddrOut  <= pcIn;
                    end else if (pcValid) begin
                        missAddr <= {pcIn[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
                    end
                end
                REQ: begin
                    // Invalidate up front so a lookup can never hit a half-filled line
                    if (memReqReady) begin
                        validArr[missIndex] <= 1'b0;
                        beatCnt             <= '0;
                    end
                end
                REFILL: begin
                    if (memDataValid) beatCnt <= beatCnt + 1'b1;
                    if (lastBeat)     validArr[missIndex] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; the valid bits guard them
    always_ff @(posedge clockIn) begin
        if (state == REFILL && memDataValid) begin
            dataArr[missIndex][beatCnt] <= memData;
            if (lastBeat) tagArr[missIndex] <= missTag;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: refill, hits, conflict eviction,
// stalled request, mid-refill PC change and reset during refill.
module tb_instruction_cache;
    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        pcValid;
    logic [31:0] pcIn;
    logic        instrOutValid;
    logic [31:0] instrOut;
    logic [31:0] instrAddrOut;
    logic        memReqValid;
    logic [31:0] memReqAddr;
    logic        memReqReady;
    logic        memDataValid;
    logic [31:0] memData;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] LINE_A = {32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013};
    localparam logic [127:0] LINE_B = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
    localparam logic [127:0] LINE_C = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
    localparam logic [127:0] LINE_D = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

    instruction_cache #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
        .clockIn       (clockIn),
        .resetIn       (resetIn),
        .pcValid       (pcValid),
        .pcIn          (pcIn),
        .instrOutValid (instrOutValid),
        .instrOut      (instrOut),
        .instrAddrOut  (instrAddrOut),
        .memReqValid   (memReqValid),
        .memReqAddr    (memReqAddr),
        .memReqReady   (memReqReady),
        .memDataValid  (memDataValid),
        .memData       (memData)
    );

    always #5 clockIn = ~clockIn;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clockIn);
        #1;
    endtask

    // Wait for the request, optionally stall ready, then stream the line.
    // After beat 1 the requester's pcIn is replaced with newPc.
    task automatic serveMiss(input logic [31:0] expAddr, input logic [127:0] line,
                             input int readyDelay, input int gap, input logic [31:0] newPc);
        int n = 0;
        while (!memReqValid && n < 20) begin
            tick();
            n++;
        end
        checkVal("reqSeen", {31'b0, memReqValid}, 32'd1);
        checkVal("reqAddr", memReqAddr, expAddr);
        for (int i = 0; i < readyDelay; i++) begin
            tick();
            checkVal("reqHoldValid", {31'b0, memReqValid}, 32'd1);
            checkVal("reqHoldAddr", memReqAddr, expAddr);
        end
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        checkVal("reqDropped", {31'b0, memReqValid}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                checkVal("gapNoOut", {31'b0, instrOutValid}, 32'd0);
            end
            memDataValid = 1'b1;
            memData      = line[32*b +: 32];
            tick();
            memDataValid = 1'b0;
            memData      = 32'hDEADBEEF;
            checkVal("refillNoOut", {31'b0, instrOutValid}, 32'd0);
            if (b == 1) pcIn = newPc;
        end
    endtask

    task automatic expectHit(input logic [31:0] addr, input logic [31:0] word);
        pcIn = addr;
        tick();
        checkVal("hitValid", {31'b0, instrOutValid}, 32'd1);
        checkVal("hitData", instrOut, word);
        checkVal("hitAddr", instrAddrOut, addr);
        checkVal("hitNoReq", {31'b0, memReqValid}, 32'd0);
    endtask

    initial begin
        resetIn = 1'b1; pcValid = 1'b0; pcIn = '0;
        memReqReady = 1'b0; memDataValid = 1'b0; memData = '0;
        tick(); tick();
        resetIn = 1'b0;
        checkVal("rstOutValid", {31'b0, instrOutValid}, 32'd0);
        checkVal("rstReqValid", {31'b0, memReqValid}, 32'd0);
        checkVal("rstReqAddr", memReqAddr, 32'h0);
        checkVal("rstInstr", instrOut, 32'h0);
        checkVal("rstInstrAddr", instrAddrOut, 32'h0);

        // Cold miss at 0x0, ready on the second request cycle
        pcValid = 1'b1; pcIn = 32'h0;
        tick();
        checkVal("missNoOut", {31'b0, instrOutValid}, 32'd0);
        serveMiss(32'h0, LINE_A, 1, 0, 32'h0);
        expectHit(32'h0, 32'h00000013);
        // Back-to-back hits; stray data beats in IDLE must be ignored
        memDataValid = 1'b1; memData = 32'hFFFFFFFF;
        expectHit(32'h4, 32'h00100093);
        expectHit(32'h8, 32'h00200113);
        expectHit(32'hC, 32'h00300193);
        memDataValid = 1'b0;

        // Conflict on index 0 evicts the 0x0 line
        pcIn = 32'h100;
        tick();
        checkVal("conflictNoOut", {31'b0, instrOutValid}, 32'd0);
        serveMiss(32'h100, LINE_B, 0, 0, 32'h100);
        expectHit(32'h100, 32'hB0000000);
        pcIn = 32'h0;
        tick();
        checkVal("evictedMiss", {31'b0, instrOutValid}, 32'd0);
        serveMiss(32'h0, LINE_A, 0, 0, 32'h0);
        expectHit(32'h4, 32'h00100093);

        // Stalled request plus gaps between beats
        pcIn = 32'h40;
        tick();
        serveMiss(32'h40, LINE_C, 5, 2, 32'h40);
        expectHit(32'h40, 32'hC0000000);
        expectHit(32'h4C, 32'hC0000003);

        // Evict 0x40, then change pcIn mid-refill of 0x40
        pcIn = 32'h140;
        tick();
        serveMiss(32'h140, LINE_B, 0, 0, 32'h140);
        expectHit(32'h144, 32'hB0000001);
        pcIn = 32'h40;
        tick();
        serveMiss(32'h40, LINE_C, 0, 1, 32'h80);
        tick();
        checkVal("switchNoOut", {31'b0, instrOutValid}, 32'd0);
        serveMiss(32'h80, LINE_D, 0, 0, 32'h80);
        expectHit(32'h80, 32'hD0000000);
        expectHit(32'h48, 32'hC0000002);

        // Reset after two beats of a refill
        pcIn = 32'hC0;
        tick();
        checkVal("preRstReq", {31'b0, memReqValid}, 32'd1);
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        for (int b = 0; b < 2; b++) begin
            memDataValid = 1'b1; memData = 32'h11110000 + b;
            tick();
        end
        memDataValid = 1'b0;
        resetIn = 1'b1;
        tick();
        resetIn = 1'b0;
        checkVal("midRstReqValid", {31'b0, memReqValid}, 32'd0);
        checkVal("midRstOutValid", {31'b0, instrOutValid}, 32'd0);
        pcIn = 32'h40;
        tick();
        checkVal("postRstNoOut", {31'b0, instrOutValid}, 32'd0);
        serveMiss(32'h40, LINE_C, 0, 0, 32'h40);
        expectHit(32'h44, 32'hC0000001);

        pcValid = 1'b0;
        tick();
        checkVal("idleNoOut", {31'b0, instrOutValid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
